// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and encodings for the multiply/divide sequencer and HI/LO muxes
package muldiv_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT_RUN,
    S_DIV_RUN,
    S_COMMIT,
    S_DZERO,
    S_TMO
  } state_e;
  localparam logic OP_MULT       = 1'b0;
  localparam logic OP_DIV        = 1'b1;
  localparam logic HILO_SRC_MULT = 1'b0;
  localparam logic HILO_SRC_DIV  = 1'b1;
endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequences one MULT/DIV at a time over the shared units and commits HI/LO
// Ports: clk, reset (async active-low); op_valid/op_sel/op_ready request handshake; abort;
//   mult_init/mult_stop, div_init/div_stop/div_zero unit handshake; high_load/low_load and
//   mux_high_sel/mux_low_sel HI/LO control; busy, done, div_zero_exc, timeout_err status.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic op_valid,
  input  logic op_sel,
  output logic op_ready,
  input  logic abort,
  output logic mult_init,
  input  logic mult_stop,
  output logic div_init,
  input  logic div_stop,
  input  logic div_zero,
  output logic high_load,
  output logic low_load,
  output logic mux_high_sel,
  output logic mux_low_sel,
  output logic busy,
  output logic done,
  output logic div_zero_exc,
  output logic timeout_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  state_e state_q, state_d;
  logic op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic stop;
  // only the active unit's stop flag counts
  assign stop = (state_q == S_DIV_RUN) ? div_stop : mult_stop;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          op_d    = op_sel;
          cnt_d   = '0;
          state_d = (op_sel == OP_DIV) ? S_DIV_RUN : S_MULT_RUN;
        end
      end
      S_MULT_RUN, S_DIV_RUN: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        // stop is only trusted once the init pulse has gone out (cnt >= 1)
        if (abort)
          state_d = S_IDLE;
        else if (state_q == S_DIV_RUN && div_zero)
          state_d = S_DZERO;
        else if (stop && cnt_q != '0)
          state_d = S_COMMIT;
        else if (cnt_q == CNT_LAST)
          state_d = S_TMO;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_MULT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end
  assign op_ready     = state_q == S_IDLE;
  assign busy         = state_q != S_IDLE;
  assign mult_init    = state_q == S_MULT_RUN && cnt_q == '0;
  assign div_init     = state_q == S_DIV_RUN && cnt_q == '0;
  assign high_load    = state_q == S_COMMIT;
  assign low_load     = state_q == S_COMMIT;
  assign done         = state_q == S_COMMIT;
  assign div_zero_exc = state_q == S_DZERO;
  assign timeout_err  = state_q == S_TMO;
  // selects follow the latched op in every state so they are settled around the load
  assign mux_high_sel = (op_q == OP_DIV) ? HILO_SRC_DIV : HILO_SRC_MULT;
  assign mux_low_sel  = (op_q == OP_DIV) ? HILO_SRC_DIV : HILO_SRC_MULT;
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Sequencer for the shared multiply/divide resource of the multicycle CPU. It accepts one MULT or DIV request at a time from the main control unit and pulses the matching unit's start line. It waits for that unit's stop or divide-by-zero flag, then either commits the result into HI/LO (load enables plus HI/LO source-mux selects) or raises a one-cycle exception/timeout pulse. The control unit stalls on `op_ready`/`busy` instead of counting cycles itself.

## Interface
- `TIMEOUT_CYCLES`, default 40: maximum cycles spent waiting for a stop flag before aborting with `timeout_err`; legal range 2..255.
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `op_valid`  in  1  control unit requests an operation.
- `op_sel`  in  1  0 = MULT, 1 = DIV; sampled only on acceptance.
- `op_ready`  out  1  high exactly in IDLE; a request is accepted when `op_valid && op_ready` at a rising edge.
- `abort`  in  1  cancels the in-flight operation; no HI/LO write.
- `mult_init`  out  1  start pulse to the multiplier.
- `mult_stop`  in  1  multiplier result valid.
- `div_init`  out  1  start pulse to the divider.
- `div_stop`  in  1  divider result valid.
- `div_zero`  in  1  divider reports divisor = 0.
- `high_load`, `low_load`  out  1 each  HI/LO register load enables.
- `mux_high_sel`, `mux_low_sel`  out  1 each  HI/LO source select: 0 = mult, 1 = div.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse on the HI/LO commit.
- `div_zero_exc`  out  1  one-cycle pulse to the exception logic.
- `timeout_err`  out  1  one-cycle pulse when no stop arrives in time.

## Operation
- States: IDLE, MULT_RUN, DIV_RUN, COMMIT, DZERO, TMO.
- All outputs are Moore, decoded from registered state, the latched op and the wait counter.
- **IDLE**
  - On acceptance, latch `op_sel` into `op_q`, clear the counter and go to MULT_RUN or DIV_RUN.
- **MULT_RUN / DIV_RUN**
  - `mult_init` / `div_init` is high only in the first cycle of the state (counter = 0).
  - The counter increments each cycle and saturates.
  - Exit priority is highest first:
    1. `abort` → IDLE.
    2. `div_zero` (DIV_RUN only) → DZERO.
    3. Stop flag of the active unit, sampled when counter ≥ 1 → COMMIT.
    4. Counter = TIMEOUT_CYCLES−1 → TMO.
  - The inactive unit's stop flag is ignored. `div_zero` is ignored in MULT_RUN.
- **COMMIT**
  - `high_load` = `low_load` = `done` = 1.
  - `mux_high_sel` = `mux_low_sel` = `op_q`.
  - Next state is IDLE. `abort` is ignored here; the commit always completes.
- **DZERO**
  - `div_zero_exc` = 1, no loads, next state IDLE.
- **TMO**
  - `timeout_err` = 1, no loads, next state IDLE.
- Mux selects hold `op_q` in every state, so they are stable around the load.
- `op_valid` arriving while busy is not accepted; the requester holds it.

## Timing
- **Reset values**
  - State IDLE, `op_q` = 0, counter = 0.
  - `op_ready` = 1 and `busy` = 0.
  - All pulses, inits, loads and selects are 0.
- **Acceptance and start**
  - Request accepted at edge E0.
  - Init is high in cycle E0→E1; `busy` is high from E0 onward.
- **Commit latency**
  - Stop flag seen high in cycle k.
  - COMMIT occupies cycle k+1 and HI/LO capture at the end of k+1.
  - `op_ready` is high again in cycle k+2.
- **Throughput**
  - Minimum occupancy is 3 cycles: init, stop, commit.
  - Back-to-back requests are accepted every (occupancy+1) cycles.
- **Simultaneous events**
  - `div_zero` and `div_stop` in the same cycle: DZERO wins.
  - `abort` together with any flag: abort wins.
  - Stop in the same cycle the counter hits its limit: COMMIT wins.
- **Mid-operation reset**
  - Asserting `reset` returns to IDLE immediately and asynchronously.
  - No load or pulse is emitted.

## Structure
- Shared package `muldiv_pkg` holds:
  - the state enum;
  - `OP_MULT` = 1'b0 and `OP_DIV` = 1'b1;
  - `HILO_SRC_MULT` = 1'b0 and `HILO_SRC_DIV` = 1'b1, which the existing HI/LO muxes also use.
- The wait counter width is $clog2(TIMEOUT_CYCLES+1).
- Single module, no sub-module; the counter is inline.

## Test plan
- **MULT:** `op_valid`=1, `op_sel`=0 at edge 0; `mult_stop` high in cycle 33 → `mult_init` only in cycle 1; `high_load`/`low_load`/`done` high in cycle 34 with selects 0; `op_ready` high in cycle 35.
- **DIV normal:** `op_sel`=1, `div_stop` in cycle 5 → commit in cycle 6 with selects 1; no `div_zero_exc`.
- **DIV by zero:** `div_zero` and `div_stop` both high in cycle 3 → `div_zero_exc` in cycle 4; no loads; `done` stays 0.
- **Timeout:** TIMEOUT_CYCLES=8, MULT, no `mult_stop` → `timeout_err` pulse after the 8th wait cycle, then IDLE.
- **Abort and stray stop:** `abort` together with `mult_stop` → IDLE, no loads. A `div_stop` during MULT_RUN is ignored.
- **Reset and busy request:** `reset` low mid-DIV_RUN → outputs reset immediately. After release, an `op_valid` held during busy is accepted exactly once, on the first IDLE cycle.
